// File: rtl/iq_modulator.sv
// AXI-Stream IQ upconverter: y = I*cos(phi) - Q*sin(phi), 3-stage pipeline driven by an NCO.
// Optional build macro IQ_MOD_PHASE_RESET_ON_LAST_EN: an accepted tlast beat returns the NCO to phase 0.
module iq_modulator #(
    parameter int                  C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int                  C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int                  PHASE_W                = 32,
    parameter int                  LUT_AW                 = 6,
    parameter logic [PHASE_W-1:0]  FREQ_WORD              = 32'h4000_0000
) (
    input  logic                               s00_axis_aclk,
    input  logic                               s00_axis_aresetn,
    input  logic                               s00_axis_tvalid,
    input  logic                               s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]  s00_axis_tdata,
    input  logic [3:0]                         s00_axis_tstrb,
    output logic                               s00_axis_tready,
    input  logic                               m00_axis_tready,
    output logic                               m00_axis_tvalid,
    output logic                               m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]  m00_axis_tdata,
    output logic [3:0]                         m00_axis_tstrb
);

    localparam int LUT_N   = 1 << LUT_AW;
    localparam int LUT_QTR = LUT_N / 4;

    // Quarter-wave integer Taylor series in Q28; the half-up rounding is applied to the magnitude.
    function automatic logic [16*LUT_N-1:0] build_lut();
        logic [16*LUT_N-1:0] tab;
        longint pi_q28;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint mag;
        int     kk;
        logic   neg;
        tab    = {(16*LUT_N){1'b0}};
        pi_q28 = 64'sd843314857;
        for (int k = 0; k < LUT_N; k++) begin
            neg = (k >= LUT_N / 2);
            kk  = k % (LUT_N / 2);
            if (kk > LUT_QTR) begin
                kk = LUT_N / 2 - kk;
            end else begin
                kk = kk;
            end
            x    = (pi_q28 * 64'sd2 * longint'(kk)) / longint'(LUT_N);
            x2   = (x * x) >>> 28;
            term = x;
            s    = x;
            for (int n = 1; n <= 7; n++) begin
                term = -((term * x2) / (longint'(2 * n) * longint'(2 * n + 1)));
                s    = s + term;
            end
            mag = (64'sd32767 * s + 64'sd134217728) >>> 28;
            if (mag > 64'sd32767) begin
                mag = 64'sd32767;
            end else if (mag < 64'sd0) begin
                mag = 64'sd0;
            end else begin
                mag = mag;
            end
            if (neg) begin
                mag = -mag;
            end else begin
                mag = mag;
            end
            tab[16*k +: 16] = mag[15:0];
        end
        return tab;
    endfunction

    localparam logic [16*LUT_N-1:0] LUT_TABLE = build_lut();

    logic                      w_en;
    logic                      w_accept;
    logic [LUT_AW-1:0]         w_sin_addr;
    logic [LUT_AW-1:0]         w_cos_addr;
    logic signed [15:0]        w_sin;
    logic signed [15:0]        w_cos;
    logic [PHASE_W-1:0]        w_phase_next;

    logic [PHASE_W-1:0]        r_phase;
    logic                      r_v0;
    logic signed [15:0]        r_i0;
    logic signed [15:0]        r_q0;
    logic signed [15:0]        r_sin0;
    logic signed [15:0]        r_cos0;
    logic                      r_last0;
    logic [3:0]                r_strb0;
    logic                      r_v1;
    logic signed [31:0]        r_pi1;
    logic signed [31:0]        r_pq1;
    logic                      r_last1;
    logic [3:0]                r_strb1;
    logic                      r_v2;
    logic [31:0]               r_y2;
    logic                      r_last2;
    logic [3:0]                r_strb2;

    assign w_en            = !r_v2 || m00_axis_tready;
    assign s00_axis_tready = w_en && s00_axis_aresetn;
    assign w_accept        = s00_axis_tvalid && s00_axis_tready;

    assign w_sin_addr = r_phase[PHASE_W-1 -: LUT_AW];
    assign w_cos_addr = w_sin_addr + LUT_AW'(LUT_QTR);
    assign w_sin      = LUT_TABLE[{w_sin_addr, 4'd0} +: 16];
    assign w_cos      = LUT_TABLE[{w_cos_addr, 4'd0} +: 16];

    assign m00_axis_tvalid = r_v2;
    assign m00_axis_tdata  = r_y2;
    assign m00_axis_tlast  = r_last2;
    assign m00_axis_tstrb  = r_strb2;

    // NCO next phase: advances only on an accepted beat.
    always_comb begin
        w_phase_next = r_phase;
        if (w_accept) begin
`ifdef IQ_MOD_PHASE_RESET_ON_LAST_EN
            if (s00_axis_tlast) begin
                w_phase_next = {PHASE_W{1'b0}};
            end else begin
                w_phase_next = r_phase + FREQ_WORD;
            end
`else
            w_phase_next = r_phase + FREQ_WORD;
`endif
        end else begin
            w_phase_next = r_phase;
        end
    end

    // Phase accumulator and stage 0: capture beat plus its sin/cos.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_phase <= {PHASE_W{1'b0}};
            r_v0    <= 1'b0;
            r_i0    <= 16'sd0;
            r_q0    <= 16'sd0;
            r_sin0  <= 16'sd0;
            r_cos0  <= 16'sd0;
            r_last0 <= 1'b0;
            r_strb0 <= 4'd0;
        end else if (w_en) begin
            r_phase <= w_phase_next;
            r_v0    <= w_accept;
            if (w_accept) begin
                r_i0    <= $signed(s00_axis_tdata[31:16]);
                r_q0    <= $signed(s00_axis_tdata[15:0]);
                r_sin0  <= w_sin;
                r_cos0  <= w_cos;
                r_last0 <= s00_axis_tlast;
                r_strb0 <= s00_axis_tstrb;
            end
        end
    end

    // Stage 1 (products) and stage 2 (difference into the output registers).
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_v1    <= 1'b0;
            r_pi1   <= 32'sd0;
            r_pq1   <= 32'sd0;
            r_last1 <= 1'b0;
            r_strb1 <= 4'd0;
            r_v2    <= 1'b0;
            r_y2    <= 32'd0;
            r_last2 <= 1'b0;
            r_strb2 <= 4'd0;
        end else if (w_en) begin
            r_v1    <= r_v0;
            r_pi1   <= r_i0 * r_cos0;
            r_pq1   <= r_q0 * r_sin0;
            r_last1 <= r_last0;
            r_strb1 <= r_strb0;
            r_v2    <= r_v1;
            // Low 32 bits of the 33-bit difference; |y| < 2^31 so nothing is lost.
            r_y2    <= r_pi1 - r_pq1;
            r_last2 <= r_last1;
            r_strb2 <= r_strb1;
        end
    end

endmodule
